// File: rtl/controle_climatizacao.sv
// Climate control stage: turns button presses into desired-temperature steps, ramps the
// real temperature toward it at a fixed rate and counts condensate drips while cooling.
module controle_climatizacao #(
  parameter int TBITS       = 3,
  parameter int TMIN        = 0,
  parameter int TMAX        = 7,
  parameter int TAMB        = 7,
  parameter int STEP_CYCLES = 4,
  parameter int DRIP_PERIOD = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             aumenta,
  input  logic             diminui,
  output logic [TBITS-1:0] desejo,
  output logic [TBITS-1:0] real_o,
  output logic [1:0]       estado,
  output logic             pingando,
  output logic [3:0]       gotas
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam int DW = $clog2(DRIP_PERIOD);
  localparam logic [TBITS-1:0] TMIN_C    = TBITS'(TMIN);
  localparam logic [TBITS-1:0] TMAX_C    = TBITS'(TMAX);
  localparam logic [TBITS-1:0] TAMB_C    = TBITS'(TAMB);
  localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0]    DRIP_LAST = DW'(DRIP_PERIOD - 1);

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    RESFRIANDO = 2'b01,
    AQUECENDO  = 2'b10
  } estado_t;

  logic             aumenta_q, diminui_q;
  logic [TBITS-1:0] desejo_q, desejo_d;
  logic [TBITS-1:0] real_q, real_d;
  logic [SW-1:0]    timer_q, timer_d;
  logic [DW-1:0]    drip_q, drip_d;
  logic             ping_q, ping_d;
  logic [3:0]       gotas_q, gotas_d;
  logic             up_ev, dn_ev, press;
  estado_t          estado_w;

  assign up_ev = aumenta & ~aumenta_q;
  assign dn_ev = diminui & ~diminui_q;
  // Simultaneous up and down events cancel each other entirely.
  assign press = up_ev ^ dn_ev;

  always_comb begin
    if (real_q == desejo_q)     estado_w = OCIOSO;
    else if (real_q > desejo_q) estado_w = RESFRIANDO;
    else                        estado_w = AQUECENDO;
  end

  always_comb begin
    desejo_d = desejo_q;
    if (up_ev && !dn_ev && desejo_q != TMAX_C) desejo_d = desejo_q + TBITS'(1);
    if (dn_ev && !up_ev && desejo_q != TMIN_C) desejo_d = desejo_q - TBITS'(1);

    // A press restarts the step interval and suppresses any step due this cycle.
    real_d  = real_q;
    timer_d = timer_q + SW'(1);
    if (estado_w == OCIOSO || press) begin
      timer_d = '0;
    end else if (timer_q == STEP_LAST) begin
      timer_d = '0;
      real_d  = (estado_w == RESFRIANDO) ? real_q - TBITS'(1) : real_q + TBITS'(1);
    end

    drip_d  = drip_q;
    ping_d  = 1'b0;
    gotas_d = gotas_q;
    if (estado_w == RESFRIANDO) begin
      if (drip_q == DRIP_LAST) begin
        drip_d = '0;
        ping_d = 1'b1;
        if (gotas_q != 4'hF) gotas_d = gotas_q + 4'd1;
      end else begin
        drip_d = drip_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      aumenta_q <= 1'b0;
      diminui_q <= 1'b0;
      desejo_q  <= TAMB_C;
      real_q    <= TAMB_C;
      timer_q   <= '0;
      drip_q    <= '0;
      ping_q    <= 1'b0;
      gotas_q   <= '0;
    end else begin
      aumenta_q <= aumenta;
      diminui_q <= diminui;
      desejo_q  <= desejo_d;
      real_q    <= real_d;
      timer_q   <= timer_d;
      drip_q    <= drip_d;
      ping_q    <= ping_d;
      gotas_q   <= gotas_d;
    end
  end

  assign desejo   = desejo_q;
  assign real_o   = real_q;
  assign estado   = estado_w;
  assign pingando = ping_q;
  assign gotas    = gotas_q;

endmodule
